// File: rtl/switch_debounce.sv
// Purpose: synchronise and debounce N_SW raw switch lines into clean levels plus rise/fall/any strobes.
// Latency: a raw step reaches sw_clean and its strobe DEBOUNCE_CYCLES+2 clock edges later.
// Backpressure: none; free-running conditioner, and strobes are single-cycle pulses that cannot be stalled.
module switch_debounce #(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_any
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        STABLE,
        CANDIDATE
    } state_t;

    logic [N_SW-1:0] sync1;
    logic [N_SW-1:0] sync2;
    state_t          state [N_SW];
    logic [CW-1:0]   cnt   [N_SW];

    logic [N_SW-1:0] qualify;
    logic [N_SW-1:0] rise_nxt;
    logic [N_SW-1:0] fall_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // A channel qualifies on the edge where the differing level has been seen for the full window.
    always_comb begin
        qualify  = '0;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < N_SW; i++) begin
            qualify[i] = (state[i] == CANDIDATE) && (sync2[i] != sw_clean[i]) && (cnt[i] == CNT_LAST);
        end
        rise_nxt = qualify & sync2;
        fall_nxt = qualify & ~sync2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_clean <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            sw_any   <= 1'b0;
            for (int i = 0; i < N_SW; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            sw_clean <= sw_clean ^ qualify;
            sw_rise  <= rise_nxt;
            sw_fall  <= fall_nxt;
            sw_any   <= |(rise_nxt | fall_nxt);
            for (int i = 0; i < N_SW; i++) begin
                case (state[i])
                    STABLE: begin
                        if (sync2[i] != sw_clean[i]) begin
                            state[i] <= CANDIDATE;
                            cnt[i]   <= CNT_ONE;
                        end else begin
                            cnt[i]   <= '0;
                        end
                    end
                    CANDIDATE: begin
                        if (sync2[i] == sw_clean[i]) begin
                            state[i] <= STABLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i] <= STABLE;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i]   <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= STABLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Purpose: scoreboard bench for switch_debounce with N_SW=4, DEBOUNCE_CYCLES=4.
// Latency: expected strobes are queued at stimulus time with their edge index and checked by a monitor.
// Backpressure: none; the monitor checks every cycle in which any strobe is presented.
module tb_switch_debounce;

    localparam int N   = 4;
    localparam int D   = 4;
    localparam int LAT = D + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_clean;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic         sw_any;

    switch_debounce #(
        .N_SW            (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_any   (sw_any)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] clean;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    logic [N-1:0] model_clean = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raw change made now is first sampled on the next edge; clean follows LAT edges after this one.
    task automatic expect_change(input logic [N-1:0] new_clean, input int at_edge);
        exp_t x;
        x.cyc   = at_edge;
        x.rise  = new_clean & ~model_clean;
        x.fall  = ~new_clean & model_clean;
        x.clean = new_clean;
        q.push_back(x);
        model_clean = new_clean;
    endtask

    always @(negedge clk) begin
        if (sw_any || (|sw_rise) || (|sw_fall)) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", {23'd0, sw_rise, sw_fall, sw_any}, 32'd0);
            end else begin
                e = q.pop_front();
                check("strobe_edge", edge_n, e.cyc);
                check("strobe_rise", {28'd0, sw_rise}, {28'd0, e.rise});
                check("strobe_fall", {28'd0, sw_fall}, {28'd0, e.fall});
                check("strobe_clean", {28'd0, sw_clean}, {28'd0, e.clean});
                check("strobe_any", {31'd0, sw_any}, 32'd1);
            end
        end else if (q.size() > 0 && edge_n >= q[0].cyc) begin
            e = q.pop_front();
            check("missed_strobe", {28'd0, sw_rise | sw_fall}, {28'd0, e.rise | e.fall});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        sw_raw = '0;
        step(3);
        check("reset_clean", {28'd0, sw_clean}, 32'd0);
        check("reset_rise",  {28'd0, sw_rise},  32'd0);
        check("reset_fall",  {28'd0, sw_fall},  32'd0);
        check("reset_any",   {31'd0, sw_any},   32'd0);
        rst = 1'b0;
        step(20);
        check("idle_clean", {28'd0, sw_clean}, 32'd0);

        // clean step on channel 0, up then down
        sw_raw[0] = 1'b1;
        expect_change(4'b0001, edge_n + LAT);
        step(12);
        sw_raw[0] = 1'b0;
        expect_change(4'b0000, edge_n + LAT);
        step(12);
        check("step_clean", {28'd0, sw_clean}, 32'd0);

        // bouncing channel 1: 2-cycle pulses rejected, final level accepted once
        for (int i = 0; i < 4; i++) begin
            sw_raw[1] = ~i[0];
            step(2);
        end
        sw_raw[1] = 1'b1;
        expect_change(4'b0010, edge_n + LAT);
        step(12);
        check("bounce_clean", {28'd0, sw_clean}, 32'd2);

        // 3-cycle glitch on channel 2 never qualifies
        sw_raw[2] = 1'b1;
        step(3);
        sw_raw[2] = 1'b0;
        step(12);
        check("glitch_clean", {28'd0, sw_clean}, 32'd2);

        sw_raw = 4'b0000;
        expect_change(4'b0000, edge_n + LAT);
        step(12);

        // all channels together
        sw_raw = 4'b1111;
        expect_change(4'b1111, edge_n + LAT);
        step(12);
        check("simul_clean", {28'd0, sw_clean}, 32'hf);
        sw_raw = 4'b0000;
        expect_change(4'b0000, edge_n + LAT);
        step(12);

        // reset during a count discards it; channel 3 requalifies from release
        sw_raw = 4'b1000;
        step(3);
        rst = 1'b1;
        step(3);
        check("midrst_clean", {28'd0, sw_clean}, 32'd0);
        check("midrst_rise",  {28'd0, sw_rise},  32'd0);
        rst = 1'b0;
        expect_change(4'b1000, edge_n + LAT);
        step(12);
        check("midrst_after_clean", {28'd0, sw_clean}, 32'h8);

        step(2);
        check("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
